// File: rtl/adc_serial_rx_multi.sv
// Multi-channel serial ADC receiver: generates CS/SCLK from the system clock and
// captures N_CH MSB-first data lines in parallel, single-shot or continuous.
module adc_serial_rx_multi #(
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int CLK_DIV       = 2,
    parameter int N_CH          = 2,
    parameter int SAMPLE_PERIOD = 80
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      cont,
    input  logic [N_CH-1:0]           adc_data,
    output logic                      adc_cs_n,
    output logic                      adc_sclk,
    output logic                      busy,
    output logic                      rx_done_tick,
    output logic [N_CH*DATA_BITS-1:0] data_out,
    output logic [N_CH-1:0]           frame_err
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    // A divide-by-one still needs a one-bit counter to be a legal vector.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = $clog2(SAMPLE_PERIOD);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StDone,
        StQuiet
    } state_e;

    state_e                      state_q, state_d;
    logic                        cs_q, cs_d;
    logic                        sclk_q, sclk_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [PER_W-1:0]            per_q, per_d;
    logic [N_CH*FRAME_BITS-1:0]  sr_q, sr_d;
    logic [N_CH*DATA_BITS-1:0]   data_q, data_d;
    logic [N_CH-1:0]             err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = data_q;
        err_d   = err_q;
        // Period counter runs from the CS falling edge and sticks at its last value.
        per_d   = (per_q == PER_LAST) ? per_q : per_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                if (start || cont) begin
                    state_d = StSetup;
                    cs_d    = 1'b0;
                    per_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            StSetup: begin
                if (div_q == DIV_LAST) begin
                    state_d = StShift;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 1'b1;
                        for (int c = 0; c < N_CH; c++) begin
                            sr_d[c*FRAME_BITS +: FRAME_BITS] =
                                {sr_q[c*FRAME_BITS +: FRAME_BITS-1], adc_data[c]};
                        end
                    end else if (bit_q == BIT_LAST) begin
                        state_d = StDone;
                        cs_d    = 1'b1;
                        for (int c = 0; c < N_CH; c++) begin
                            data_d[c*DATA_BITS +: DATA_BITS] = sr_q[c*FRAME_BITS +: DATA_BITS];
                            err_d[c] = |sr_q[c*FRAME_BITS+DATA_BITS +: FRAME_BITS-DATA_BITS];
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            StDone: begin
                state_d = StQuiet;
            end
            StQuiet: begin
                if (per_q == PER_LAST) begin
                    per_d = '0;
                    if (cont) begin
                        state_d = StSetup;
                        cs_d    = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    assign adc_cs_n     = cs_q;
    assign adc_sclk     = sclk_q;
    assign busy         = (state_q != StIdle);
    assign rx_done_tick = (state_q == StDone);
    assign data_out     = data_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Directed bench for adc_serial_rx_multi: default 2-channel instance plus a
// CLK_DIV=1, 8-bit single-channel instance, each driven by a small ADC model.
module tb_adc_serial_rx_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, cont = 1'b0;
    logic [1:0]  adc_data = '0;
    logic        cs_n, sclk, busy, tick;
    logic [23:0] data_out;
    logic [1:0]  frame_err;

    logic        start_s = 1'b0, cont_s = 1'b0;
    logic [0:0]  adc_data_s = '0;
    logic        cs_n_s, sclk_s, busy_s, tick_s;
    logic [5:0]  data_out_s;
    logic [0:0]  frame_err_s;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_serial_rx_multi dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .adc_data(adc_data),
        .adc_cs_n(cs_n), .adc_sclk(sclk), .busy(busy), .rx_done_tick(tick),
        .data_out(data_out), .frame_err(frame_err)
    );

    adc_serial_rx_multi #(
        .FRAME_BITS(8), .DATA_BITS(6), .CLK_DIV(1), .N_CH(1), .SAMPLE_PERIOD(24)
    ) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .cont(cont_s), .adc_data(adc_data_s),
        .adc_cs_n(cs_n_s), .adc_sclk(sclk_s), .busy(busy_s), .rx_done_tick(tick_s),
        .data_out(data_out_s), .frame_err(frame_err_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model and event monitor for the default instance.
    logic [15:0] frame0 = '0, frame1 = '0;
    int idx = 0, n_cs_falls = 0, tick_cnt = 0, sclk_falls = 0, sclk_rises = 0, cs_low = 0;
    int cs_fall_t[8];
    int tick_t[8];
    logic prev_cs = 1'b1, prev_sclk = 1'b1;

    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            if (n_cs_falls < 8) cs_fall_t[n_cs_falls] = cyc;
            n_cs_falls++;
            idx = 15;
        end
        if (!cs_n) cs_low++;
        if (prev_sclk && !sclk && !cs_n && idx >= 0) begin
            sclk_falls++;
            adc_data = {frame1[idx], frame0[idx]};
            idx--;
        end
        if (!prev_sclk && sclk && !cs_n) sclk_rises++;
        if (tick) begin
            if (tick_cnt < 8) tick_t[tick_cnt] = cyc;
            tick_cnt++;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    // ADC model and monitor for the swept instance.
    logic [7:0] frame_s = '0;
    int idx_s = 0, tick_cnt_s = 0, tick_t_s = 0;
    logic prev_sclk_s = 1'b1;

    always @(negedge clk) begin
        if (!cs_n_s && prev_sclk_s && !sclk_s && idx_s >= 0) begin
            adc_data_s = frame_s[idx_s];
            idx_s--;
        end
        if (cs_n_s) idx_s = 7;
        if (tick_s) begin
            tick_cnt_s++;
            tick_t_s = cyc;
        end
        prev_sclk_s = sclk_s;
    end

    task automatic clear_counts();
        n_cs_falls = 0; tick_cnt = 0; sclk_falls = 0; sclk_rises = 0; cs_low = 0;
    endtask

    task automatic pulse_start(output int k);
        @(posedge clk); #1;
        k = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_ticks(input string tag, input int target, input int budget);
        int n = 0;
        while (tick_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, tick_cnt, target);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    initial begin
        int k;
        int n;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;

        // Reset values
        #12;
        check_eq("rst_cs_n", cs_n, 1'b1);
        check_eq("rst_sclk", sclk, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tick", tick, 1'b0);
        check_eq("rst_data", data_out, 24'h0);
        check_eq("rst_err", frame_err, 2'b00);
        check_eq("rst_s_cs_sclk", {cs_n_s, sclk_s, busy_s}, 3'b110);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single shot, defaults
        frame0 = 16'h0ABC; frame1 = 16'h0123;
        clear_counts();
        pulse_start(k);
        wait_ticks("single_tick_seen", 1, 200);
        check_eq("single_tick_time", tick_t[0] - k, 67);
        check_eq("single_data", data_out, 24'h123ABC);
        check_eq("single_err", frame_err, 2'b00);
        check_eq("single_sclk_falls", sclk_falls, 16);
        check_eq("single_cs_low", cs_low, 66);
        check_eq("single_cs_fall", cs_fall_t[0] - k, 1);
        wait_idle("single_idle", 200);

        // Frame error on ch1
        frame0 = 16'h0555; frame1 = 16'h8FFF;
        clear_counts();
        pulse_start(k);
        wait_ticks("ferr_tick_seen", 1, 200);
        check_eq("ferr_err", frame_err, 2'b10);
        check_eq("ferr_ch1", data_out[23:12], 12'hFFF);
        check_eq("ferr_ch0", data_out[11:0], 12'h555);
        wait_idle("ferr_idle", 200);

        // Continuous mode, cont dropped during the third frame
        frame0 = 16'h0321; frame1 = 16'h0654;
        clear_counts();
        @(posedge clk); #1;
        cont = 1'b1;
        n = 0;
        while (n_cs_falls < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("cont_third_cs", n_cs_falls, 3);
        repeat (10) @(posedge clk);
        #1 cont = 1'b0;
        wait_idle("cont_idle", 300);
        repeat (100) @(negedge clk);
        check_eq("cont_cs_falls", n_cs_falls, 3);
        check_eq("cont_ticks", tick_cnt, 3);
        check_eq("cont_cs_gap1", cs_fall_t[1] - cs_fall_t[0], 80);
        check_eq("cont_cs_gap2", cs_fall_t[2] - cs_fall_t[1], 80);
        check_eq("cont_tick_gap1", tick_t[1] - tick_t[0], 80);
        check_eq("cont_tick_gap2", tick_t[2] - tick_t[1], 80);
        check_eq("cont_tick_lat", tick_t[0] - cs_fall_t[0], 66);
        check_eq("cont_data", data_out, 24'h654321);
        check_eq("cont_busy", busy, 1'b0);

        // Reset after the 7th SCLK rise
        frame0 = 16'h0AAA; frame1 = 16'h0BBB;
        clear_counts();
        pulse_start(k);
        n = 0;
        while (sclk_rises < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstmid_rises", sclk_rises, 7);
        #2 reset = 1'b0;
        #1;
        check_eq("rstmid_cs_n", cs_n, 1'b1);
        check_eq("rstmid_sclk", sclk, 1'b1);
        check_eq("rstmid_data", data_out, 24'h0);
        check_eq("rstmid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check_eq("rstmid_no_tick", tick_cnt, 0);
        frame0 = 16'h0F0F; frame1 = 16'h0777;
        clear_counts();
        pulse_start(k);
        wait_ticks("rstmid_after_tick", 1, 200);
        check_eq("rstmid_after_time", tick_t[0] - k, 67);
        check_eq("rstmid_after_data", data_out, 24'h777F0F);
        wait_idle("rstmid_after_idle", 200);

        // Start pulses while busy are ignored
        frame0 = 16'h0246; frame1 = 16'h0135;
        clear_counts();
        pulse_start(k);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("busy_idle", 300);
        repeat (20) @(negedge clk);
        check_eq("busy_ticks", tick_cnt, 1);
        check_eq("busy_cs_falls", n_cs_falls, 1);
        check_eq("busy_tick_time", tick_t[0] - k, 67);
        check_eq("busy_data", data_out, 24'h135246);

        // Parameter sweep instance
        frame_s = 8'h2D;
        @(posedge clk); #1;
        k = cyc;
        start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        n = 0;
        while (tick_cnt_s < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sweep_tick_seen", tick_cnt_s, 1);
        check_eq("sweep_tick_time", tick_t_s - k, 18);
        check_eq("sweep_data", data_out_s, 6'h2D);
        check_eq("sweep_err", frame_err_s, 1'b0);
        repeat (40) @(negedge clk);
        check_eq("sweep_idle", busy_s, 1'b0);
        frame_s = 8'hC5;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        n = 0;
        while (tick_cnt_s < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("sweep2_tick_seen", tick_cnt_s, 2);
        check_eq("sweep2_data", data_out_s, 6'h05);
        check_eq("sweep2_err", frame_err_s, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
